// File: rtl/johnson_decoder.sv
// johnson_decoder
//   Receive-side partner of a Johnson counter. Registers an N-bit Johnson code
//   word, converts it to a phase index 0..2N-1, and flags illegal words
//   (code_err) and out-of-sequence steps (step_err). A three-state lock FSM
//   qualifies the incoming stream.
//   Two-stage pipeline: stage 1 captures code_in on sample_en; stage 2 decodes,
//   checks and drives the registered outputs (2-cycle latency).
//   Optional feature macro: JOHNSON_DEC_BIDIR_EN
//     defined   -> down steps (prev-1 mod 2N) are also accepted and a 'dir'
//                  port reports the last accepted step direction (1 = down)
//     undefined -> a down step is a step_err and 'dir' does not exist
module johnson_decoder #(
  parameter int N        = 8,
  parameter int LOCK_CNT = 4,
  localparam int W       = $clog2(2*N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] code_in,
  input  logic         sample_en,
  output logic [W-1:0] count_out,
  output logic         count_vld,
  output logic         locked,
  output logic         code_err,
  output logic         step_err,
  output logic [7:0]   err_count
`ifdef JOHNSON_DEC_BIDIR_EN
  ,
  output logic         dir
`endif
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } lockState_t;

  localparam logic [W-1:0] LP_LAST_IDX = W'(2*N-1);
  localparam logic [3:0]   LP_LOCK_CNT = 4'(LOCK_CNT);

  // Stage 1 registers
  logic         r_s1Vld;
  logic [N-1:0] r_s1Code;

  // Stage 2 state
  lockState_t   r_state;
  logic [3:0]   r_run;
  logic [W-1:0] r_prev;

  // Decode / check wires
  logic         w_msb;
  logic [N-1:0] w_word;
  logic [N-1:0] w_wordInc;
  logic         w_legal;
  logic [W-1:0] w_pop;
  logic [W-1:0] w_idx;
  logic [W-1:0] w_prevUp;
  logic [W-1:0] w_prevDown;
  logic         w_isEq;
  logic         w_isUp;
  logic         w_isDown;
  logic         w_stepOk;
  logic         w_stepErr;
  logic         w_codeErr;
  logic [3:0]   w_runInc;

  // Stage 1: capture the code word; an idle cycle leaves the word but clears valid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1Vld  <= 1'b0;
      r_s1Code <= '0;
    end else begin
      r_s1Vld <= sample_en;
      if (sample_en) begin
        r_s1Code <= code_in;
      end
    end
  end

  // Legality test, popcount decode and step classification of the stage-1 word
  always_comb begin
    w_msb     = r_s1Code[N-1];
    // With the MSB set the word is in its "ones draining" half; invert it so a
    // single packed-ones-at-LSB test covers both halves.
    w_word    = w_msb ? ~r_s1Code : r_s1Code;
    w_wordInc = w_word + {{(N-1){1'b0}}, 1'b1};
    w_legal   = ((w_word & w_wordInc) == '0);

    w_pop = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + W'(r_s1Code[i]);
    end
    // MSB set implies popcount >= 1, so (2N-1 - p) + 1 never leaves W bits
    w_idx = w_msb ? ((LP_LAST_IDX - w_pop) + {{(W-1){1'b0}}, 1'b1}) : w_pop;

    w_prevUp   = (r_prev == LP_LAST_IDX) ? '0 : (r_prev + {{(W-1){1'b0}}, 1'b1});
    w_prevDown = (r_prev == '0) ? LP_LAST_IDX : (r_prev - {{(W-1){1'b0}}, 1'b1});

    w_isEq   = (w_idx == r_prev);
    w_isUp   = (w_idx == w_prevUp);
    w_isDown = (w_idx == w_prevDown);
`ifdef JOHNSON_DEC_BIDIR_EN
    w_stepOk = w_isEq || w_isUp || w_isDown;
`else
    w_stepOk = w_isEq || w_isUp;
`endif

    // Code errors take priority; step errors are only meaningful once a prev exists
    w_codeErr = r_s1Vld && !w_legal;
    w_stepErr = r_s1Vld && w_legal && !w_stepOk && (r_state != ST_UNLOCKED);
    w_runInc  = r_run + 4'd1;
  end

  // Stage 2: lock FSM plus registered count/flag outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_UNLOCKED;
      r_run     <= 4'd0;
      r_prev    <= '0;
      count_out <= '0;
      count_vld <= 1'b0;
      locked    <= 1'b0;
      code_err  <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      count_vld <= 1'b0;
      code_err  <= 1'b0;
      step_err  <= 1'b0;
      if (r_s1Vld) begin
        if (!w_legal) begin
          code_err <= 1'b1;
          r_state  <= ST_UNLOCKED;
          r_run    <= 4'd0;
          locked   <= 1'b0;
        end else begin
          count_vld <= 1'b1;
          count_out <= w_idx;
          r_prev    <= w_idx;
          case (r_state)
            ST_UNLOCKED: begin
              r_run <= 4'd1;
              if (LP_LOCK_CNT == 4'd1) begin
                r_state <= ST_LOCKED;
                locked  <= 1'b1;
              end else begin
                r_state <= ST_LOCKING;
              end
            end
            ST_LOCKING: begin
              if (w_stepOk) begin
                r_run <= w_runInc;
                if (w_runInc == LP_LOCK_CNT) begin
                  r_state <= ST_LOCKED;
                  locked  <= 1'b1;
                end
              end else begin
                step_err <= 1'b1;
                r_state  <= ST_UNLOCKED;
                r_run    <= 4'd0;
              end
            end
            ST_LOCKED: begin
              if (!w_stepOk) begin
                step_err <= 1'b1;
                r_state  <= ST_UNLOCKED;
                r_run    <= 4'd0;
                locked   <= 1'b0;
              end
            end
            default: begin
              r_state <= ST_UNLOCKED;
              r_run   <= 4'd0;
              locked  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Saturating error tally; one increment per code_err or step_err pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if ((w_codeErr || w_stepErr) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

`ifdef JOHNSON_DEC_BIDIR_EN
  // Direction of the last accepted step; equal-index samples leave it alone
  always_ff @(posedge clk) begin
    if (reset) begin
      dir <= 1'b0;
    end else if (r_s1Vld && w_legal && w_stepOk && (r_state != ST_UNLOCKED) && !w_isEq) begin
      dir <= w_isUp ? 1'b0 : 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder
//   Directed self-checking bench for johnson_decoder (N=8, LOCK_CNT=4).
//   Expected values are hand-computed constants. Works with or without
//   JOHNSON_DEC_BIDIR_EN defined.
module tb_johnson_decoder;

  localparam int N = 8;
  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] code_in;
  logic         sample_en;
  logic [W-1:0] count_out;
  logic         count_vld;
  logic         locked;
  logic         code_err;
  logic         step_err;
  logic [7:0]   err_count;
`ifdef JOHNSON_DEC_BIDIR_EN
  logic         dir;
`endif

  int assertCount = 0;
  int failCount   = 0;

  johnson_decoder #(.N(N), .LOCK_CNT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .code_in   (code_in),
    .sample_en (sample_en),
    .count_out (count_out),
    .count_vld (count_vld),
    .locked    (locked),
    .code_err  (code_err),
    .step_err  (step_err),
    .err_count (err_count)
`ifdef JOHNSON_DEC_BIDIR_EN
    ,
    .dir       (dir)
`endif
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Send one isolated sample; returns at the negedge where its result is visible
  task automatic applyStimulus(input logic [N-1:0] code);
    @(negedge clk);
    code_in   = code;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
  endtask

  // Check a legal, error-free sample result
  task automatic checkGood(input string tag, input logic [W-1:0] idx, input logic lockExp);
    checkOutput({tag, " vld"}, 32'(count_vld), 32'd1);
    checkOutput({tag, " cnt"}, 32'(count_out), 32'(idx));
    checkOutput({tag, " cerr"}, 32'(code_err), 32'd0);
    checkOutput({tag, " serr"}, 32'(step_err), 32'd0);
    checkOutput({tag, " lock"}, 32'(locked), 32'(lockExp));
  endtask

  logic [N-1:0] cycleCodes [17] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                    8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [W-1:0] cycleIdx   [17] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                    4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
  logic [N-1:0] downCodes  [7]  = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

  initial begin
    reset     = 1'b1;
    code_in   = '0;
    sample_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst cnt", 32'(count_out), 32'd0);
    checkOutput("rst vld", 32'(count_vld), 32'd0);
    checkOutput("rst lock", 32'(locked), 32'd0);
    checkOutput("rst cerr", 32'(code_err), 32'd0);
    checkOutput("rst serr", 32'(step_err), 32'd0);
    checkOutput("rst ecnt", 32'(err_count), 32'd0);
`ifdef JOHNSON_DEC_BIDIR_EN
    checkOutput("rst dir", 32'(dir), 32'd0);
`endif

    // Test 1: full cycle back-to-back; result of sample k visible 2 negedges later
    $display("[TB] test 1: full Johnson cycle");
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checkGood($sformatf("t1 s%0d", i - 2), cycleIdx[i-2], (i - 2) >= 3);
      end
      if (i < 17) begin
        code_in   = cycleCodes[i];
        sample_en = 1'b1;
      end else begin
        sample_en = 1'b0;
      end
    end
    checkOutput("t1 ecnt", 32'(err_count), 32'd0);

    // Test 2: locked at 0x0F, illegal 0x05
    $display("[TB] test 2: illegal word while locked");
    applyStimulus(8'h01);
    applyStimulus(8'h03);
    applyStimulus(8'h07);
    applyStimulus(8'h0F);
    checkGood("t2 pre", 4'd4, 1'b1);
    applyStimulus(8'h05);
    checkOutput("t2 cerr", 32'(code_err), 32'd1);
    checkOutput("t2 serr", 32'(step_err), 32'd0);
    checkOutput("t2 vld", 32'(count_vld), 32'd0);
    checkOutput("t2 lock", 32'(locked), 32'd0);
    checkOutput("t2 cnt", 32'(count_out), 32'd4);
    checkOutput("t2 ecnt", 32'(err_count), 32'd1);
    @(negedge clk);
    checkOutput("t2 cerr pulse", 32'(code_err), 32'd0);

    // Test 3: relock at idx 4, then jump to idx 7
    $display("[TB] test 3: step error while locked");
    applyStimulus(8'h0F);
    checkGood("t3 relock1", 4'd4, 1'b0);
    applyStimulus(8'h0F);
    applyStimulus(8'h0F);
    checkGood("t3 relock3", 4'd4, 1'b0);
    applyStimulus(8'h0F);
    checkGood("t3 relock4", 4'd4, 1'b1);
    applyStimulus(8'h7F);
    checkOutput("t3 serr", 32'(step_err), 32'd1);
    checkOutput("t3 cerr", 32'(code_err), 32'd0);
    checkOutput("t3 vld", 32'(count_vld), 32'd1);
    checkOutput("t3 cnt", 32'(count_out), 32'd7);
    checkOutput("t3 lock", 32'(locked), 32'd0);
    checkOutput("t3 ecnt", 32'(err_count), 32'd2);
    applyStimulus(8'hFF);
    checkGood("t3 run1", 4'd8, 1'b0);
    applyStimulus(8'hFF);
    applyStimulus(8'hFF);
    checkGood("t3 run3", 4'd8, 1'b0);
    applyStimulus(8'hFF);
    checkGood("t3 run4", 4'd8, 1'b1);

    // Test 4: walk to 0x80 then wrap to 0x00, then hold at 0x00
    $display("[TB] test 4: wrap and hold");
    foreach (downCodes[i]) begin
      applyStimulus(downCodes[i]);
    end
    checkGood("t4 idx15", 4'd15, 1'b1);
    applyStimulus(8'h00);
    checkGood("t4 wrap", 4'd0, 1'b1);
    applyStimulus(8'h00);
    checkGood("t4 hold", 4'd0, 1'b1);
    checkOutput("t4 ecnt", 32'(err_count), 32'd2);

    // Test 6: locked at idx 5, step down to idx 4
    $display("[TB] test 6: down step");
    applyStimulus(8'h01);
    applyStimulus(8'h03);
    applyStimulus(8'h07);
    applyStimulus(8'h0F);
    applyStimulus(8'h1F);
    checkGood("t6 pre", 4'd5, 1'b1);
`ifdef JOHNSON_DEC_BIDIR_EN
    checkOutput("t6 dir up", 32'(dir), 32'd0);
    applyStimulus(8'h0F);
    checkGood("t6 down", 4'd4, 1'b1);
    checkOutput("t6 dir down", 32'(dir), 32'd1);
    applyStimulus(8'h0F);
    checkOutput("t6 dir hold", 32'(dir), 32'd1);
    checkOutput("t6 ecnt", 32'(err_count), 32'd2);
`else
    applyStimulus(8'h0F);
    checkOutput("t6 serr", 32'(step_err), 32'd1);
    checkOutput("t6 cnt", 32'(count_out), 32'd4);
    checkOutput("t6 lock", 32'(locked), 32'd0);
    checkOutput("t6 ecnt", 32'(err_count), 32'd3);
`endif

    // Test 5: reset while 0xFF is in flight
    $display("[TB] test 5: reset drops in-flight sample");
    @(negedge clk);
    code_in   = 8'hFF;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t5 vld", 32'(count_vld), 32'd0);
    checkOutput("t5 cnt", 32'(count_out), 32'd0);
    checkOutput("t5 lock", 32'(locked), 32'd0);
    checkOutput("t5 ecnt", 32'(err_count), 32'd0);
`ifdef JOHNSON_DEC_BIDIR_EN
    checkOutput("t5 dir", 32'(dir), 32'd0);
`endif
    @(negedge clk);
    checkOutput("t5 vld late", 32'(count_vld), 32'd0);
    checkOutput("t5 cnt late", 32'(count_out), 32'd0);

    // Test 7: 300 illegal words back-to-back, saturation at 255
    $display("[TB] test 7: err_count saturation");
    for (int i = 0; i < 254; i++) begin
      @(negedge clk);
      code_in   = 8'h05;
      sample_en = 1'b1;
    end
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    checkOutput("t7 ecnt254", 32'(err_count), 32'd254);
    checkOutput("t7 cerr", 32'(code_err), 32'd1);
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      code_in   = 8'h05;
      sample_en = 1'b1;
    end
    @(negedge clk);
    sample_en = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t7 ecnt sat", 32'(err_count), 32'd255);
    checkOutput("t7 lock", 32'(locked), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
